semaforo_lamp_driver: RTL and testbench

//  Downstream of the intersection sequencing FSM: converts its change strobes (C*) and init levels (set_*) into lamp drive.

---
 rtl/semaforo_pkg.sv | 40 ++++
 rtl/semaforo_lamp.sv | 97 +++++++++
 rtl/semaforo_lamp_driver.sv | 143 ++++++++++++++
 tb/tb_semaforo_lamp_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared constants for the intersection lamp driver.
// Lamp encodings, channel indices and timing defaults.
package semaforo_pkg;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int VEH_NN = 0;
  localparam int VEH_NS = 1;
  localparam int VEH_TH = 2;

  localparam int AUX_GIRO_NN_IZQ = 0;
  localparam int AUX_GIRO_NN_DER = 1;
  localparam int AUX_GIRO_TH_IZQ = 2;
  localparam int AUX_PEATON_N    = 3;
  localparam int AUX_PEATON_TH1  = 4;
  localparam int AUX_PEATON_TH2  = 5;

  localparam int TICKS_PER_MS_DEF = 10;
  localparam int YEL_MIN_MS_DEF   = 3000;
  localparam int CLEAR_MS_DEF     = 1000;
  localparam int CNT_W_DEF        = 16;
  localparam int FLASH_HALF_MS    = 500;

  typedef enum logic [1:0] {
    ST_RED,
    ST_GRN,
    ST_YEL
  } veh_st_e;

  function automatic logic [2:0] lamp_of(veh_st_e s);
    unique case (s)
      ST_GRN:  return LAMP_G;
      ST_YEL:  return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/semaforo_lamp.sv
// One vehicle signal: RED/GREEN/YELLOW sequencer with
// minimum-yellow dwell, deferred red request and red-age.
module semaforo_lamp
  import semaforo_pkg::*;
#(
  parameter int YEL_MIN_MS = YEL_MIN_MS_DEF,
  parameter int CLEAR_MS   = CLEAR_MS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       reset_general_n,
  input  logic       tick,
  input  logic       load,
  input  logic       set_red,
  input  logic       chg,
  output logic [2:0] lamp,
  output logic       red_ok,
  output logic       dup
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] YEL_MIN = CNT_W'(YEL_MIN_MS);
  localparam logic [CNT_W-1:0] CLEAR   = CNT_W'(CLEAR_MS);

  veh_st_e          st, st_nxt;
  logic             pending, pend_nxt, dup_nxt;
  logic [CNT_W-1:0] dwell, red_age;
  logic [CNT_W-1:0] dwell_inc, age_inc, dwell_eff;
  logic             rel_now;

  assign dwell_inc = (dwell == CNT_MAX) ? dwell
                                        : dwell + CNT_W'(1);
  assign age_inc   = (red_age == CNT_MAX) ? red_age
                                          : red_age + CNT_W'(1);
  assign dwell_eff = tick ? dwell_inc : dwell;
  assign rel_now   = pending & tick & (dwell_inc >= YEL_MIN);

  always_ff @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) st <= ST_RED;
    else                  st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    pend_nxt = pending;
    dup_nxt  = 1'b0;
    if (load) begin
      st_nxt   = set_red ? ST_RED : ST_GRN;
      pend_nxt = 1'b0;
    end else begin
      unique case (st)
        ST_RED: if (chg) st_nxt = ST_GRN;
        ST_GRN: if (chg) st_nxt = ST_YEL;
        ST_YEL: begin
          if (pending) begin
            dup_nxt = chg;
            if (rel_now) begin
              st_nxt   = ST_RED;
              pend_nxt = 1'b0;
            end
          end else if (chg) begin
            // too early to drop to red: remember the request
            if (dwell_eff >= YEL_MIN) st_nxt = ST_RED;
            else                      pend_nxt = 1'b1;
          end
        end
        default: st_nxt = ST_RED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) begin
      pending <= 1'b0;
      dup     <= 1'b0;
      dwell   <= '0;
      red_age <= '0;
    end else begin
      pending <= pend_nxt;
      dup     <= dup_nxt;
      if (load || st != ST_YEL || st_nxt != ST_YEL)
        dwell <= '0;
      else if (tick)
        dwell <= dwell_inc;
      if (load || st != ST_RED || st_nxt != ST_RED)
        red_age <= '0;
      else if (tick)
        red_age <= age_inc;
    end
  end

  always_comb begin
    lamp   = lamp_of(st);
    red_ok = (st == ST_RED) && (red_age >= CLEAR);
  end

endmodule

// File: rtl/semaforo_lamp_driver.sv
// Lamp driver behind the intersection FSM: edges, aux toggles,
// red_check and idle display. FLASH_YELLOW_EN selects yellow flash.
module semaforo_lamp_driver
  import semaforo_pkg::*;
#(
  parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
  parameter int YEL_MIN_MS   = YEL_MIN_MS_DEF,
  parameter int CLEAR_MS     = CLEAR_MS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       reset_general_n,
  input  logic       enable_general,
  input  logic [2:0] chg_veh,
  input  logic [5:0] chg_aux,
  input  logic [2:0] set_veh,
  input  logic [5:0] set_aux,
  output logic [8:0] lamp_veh,
  output logic [5:0] lamp_aux,
  output logic       red_check_SemaforoNN_E6,
  output logic       dup_chg
);

  localparam int PS_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PS_W-1:0] ps_cnt;
  logic            tick, run_tick;
  logic            en_s, en_p, en_rise, run;
  logic [2:0]      veh_s, veh_p, veh_edge;
  logic [5:0]      aux_s, aux_p, aux_edge, aux_q;
  logic [8:0]      lamp_int;
  logic [2:0]      red_ok, dup_v;
  logic            red_check_q;

  assign tick = ps_cnt == PS_W'(TICKS_PER_MS - 1);

  always_ff @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) ps_cnt <= '0;
    else if (tick)        ps_cnt <= '0;
    else                  ps_cnt <= ps_cnt + PS_W'(1);
  end

  always_ff @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) begin
      en_s  <= 1'b0;
      en_p  <= 1'b0;
      veh_s <= '0;
      veh_p <= '0;
      aux_s <= '0;
      aux_p <= '0;
    end else begin
      en_s  <= enable_general;
      en_p  <= en_s;
      veh_s <= chg_veh;
      veh_p <= veh_s;
      aux_s <= chg_aux;
      aux_p <= aux_s;
    end
  end

  // a load cycle swallows any strobe edge seen alongside it
  assign en_rise  = en_s & ~en_p;
  assign run      = en_s & ~en_rise;
  assign veh_edge = veh_s & ~veh_p & {3{run}};
  assign aux_edge = aux_s & ~aux_p & {6{run}};
  assign run_tick = tick & en_s;

  for (genvar i = 0; i < 3; i++) begin : g_veh
    semaforo_lamp #(
      .YEL_MIN_MS (YEL_MIN_MS),
      .CLEAR_MS   (CLEAR_MS),
      .CNT_W      (CNT_W)
    ) u_lamp (
      .CLK             (CLK),
      .reset_general_n (reset_general_n),
      .tick            (run_tick),
      .load            (en_rise),
      .set_red         (set_veh[i]),
      .chg             (veh_edge[i]),
      .lamp            (lamp_int[3*i +: 3]),
      .red_ok          (red_ok[i]),
      .dup             (dup_v[i])
    );
  end

  always_ff @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) begin
      aux_q       <= '0;
      red_check_q <= 1'b0;
    end else begin
      aux_q       <= en_rise ? set_aux : (aux_q ^ aux_edge);
      red_check_q <= red_ok[VEH_NS] & red_ok[VEH_TH];
    end
  end

  assign dup_chg = |dup_v;

`ifdef FLASH_YELLOW_EN
  logic             flash_act, flash_on;
  logic [CNT_W-1:0] flash_ms;

  always_ff @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) begin
      flash_act <= 1'b0;
      flash_on  <= 1'b1;
      flash_ms  <= '0;
    end else if (en_s) begin
      flash_act <= 1'b0;
      flash_on  <= 1'b1;
      flash_ms  <= '0;
    end else if (en_p) begin
      flash_act <= 1'b1;
      flash_on  <= 1'b1;
      flash_ms  <= '0;
    end else if (flash_act && tick) begin
      if (flash_ms == CNT_W'(FLASH_HALF_MS - 1)) begin
        flash_ms <= '0;
        flash_on <= ~flash_on;
      end else begin
        flash_ms <= flash_ms + CNT_W'(1);
      end
    end
  end

  always_comb begin
    lamp_veh                = lamp_int;
    lamp_aux                = aux_q;
    red_check_SemaforoNN_E6 = red_check_q;
    if (flash_act) begin
      lamp_veh                = {3{1'b0, flash_on, 1'b0}};
      lamp_aux                = '0;
      red_check_SemaforoNN_E6 = 1'b0;
    end
  end
`else
  always_comb begin
    lamp_veh                = lamp_int;
    lamp_aux                = aux_q;
    red_check_SemaforoNN_E6 = red_check_q;
  end
`endif

endmodule

// File: tb/tb_semaforo_lamp_driver.sv
// Scoreboard bench for semaforo_lamp_driver: directed strobes,
// expected outputs queued by cycle and checked by a monitor.
module tb_semaforo_lamp_driver;

  logic       CLK = 1'b0;
  logic       reset_general_n;
  logic       enable_general;
  logic [2:0] chg_veh, set_veh;
  logic [5:0] chg_aux, set_aux;
  logic [8:0] lamp_veh;
  logic [5:0] lamp_aux;
  logic       red_check_SemaforoNN_E6;
  logic       dup_chg;

  semaforo_lamp_driver dut (
    .CLK                     (CLK),
    .reset_general_n         (reset_general_n),
    .enable_general          (enable_general),
    .chg_veh                 (chg_veh),
    .chg_aux                 (chg_aux),
    .set_veh                 (set_veh),
    .set_aux                 (set_aux),
    .lamp_veh                (lamp_veh),
    .lamp_aux                (lamp_aux),
    .red_check_SemaforoNN_E6 (red_check_SemaforoNN_E6),
    .dup_chg                 (dup_chg)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK or negedge reset_general_n) begin
    if (!reset_general_n) cyc <= 0;
    else                  cyc <= cyc + 1;
  end

  typedef struct {
    int         at;
    string      nm;
    logic [8:0] veh;
    logic [5:0] aux;
    logic       rc;
    logic       dup;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      me = sb.pop_front();
      n_vec++;
      if (me.at != cyc || lamp_veh !== me.veh || lamp_aux !== me.aux ||
          red_check_SemaforoNN_E6 !== me.rc || dup_chg !== me.dup) begin
        n_bad++;
        $display("FAIL %s cyc=%0d(want %0d): veh=%h aux=%b rc=%b dup=%b, required veh=%h aux=%b rc=%b dup=%b",
                 me.nm, cyc, me.at, lamp_veh, lamp_aux,
                 red_check_SemaforoNN_E6, dup_chg,
                 me.veh, me.aux, me.rc, me.dup);
      end
    end
  end

  task automatic expect_abs(input int at, input string nm,
                            input logic [8:0] v, input logic [5:0] a,
                            input logic rc, input logic d);
    exp_t e;
    e.at = at; e.nm = nm; e.veh = v; e.aux = a; e.rc = rc; e.dup = d;
    sb.push_back(e);
  endtask

  task automatic expect_in(input int dc, input string nm,
                           input logic [8:0] v, input logic [5:0] a,
                           input logic rc, input logic d);
    expect_abs(cyc + dc, nm, v, a, rc, d);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) @(negedge CLK);
  endtask

  task automatic pulse_veh(input int i);
    chg_veh[i] = 1'b1;
    @(negedge CLK);
    chg_veh[i] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never reached, required 0",
               sb.size());
      $fatal(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int ld, t_rc, ye, r_th;
`ifdef FLASH_YELLOW_EN
    int f1;
`endif
    reset_general_n = 1'b0;
    enable_general  = 1'b0;
    chg_veh = '0; chg_aux = '0; set_veh = '0; set_aux = '0;
    @(negedge CLK);
    expect_abs(0, "rst", 9'h124, 6'h00, 1'b0, 1'b0);
    step(2);
    reset_general_n = 1'b1;
    step(3);

    // strobes ignored while disabled
    chg_veh = 3'b001;
    expect_in(2, "idle_ign", 9'h124, 6'h00, 1'b0, 1'b0);
    @(negedge CLK);
    chg_veh = '0;
    step(4);

    // enable rise loads, same-cycle aux strobe ignored
    set_veh = 3'b110; set_aux = 6'b101001;
    enable_general = 1'b1;
    chg_aux = 6'b000001;
    ld = cyc + 2;
    expect_in(1, "pre_load", 9'h124, 6'h00, 1'b0, 1'b0);
    expect_in(2, "load", 9'h121, 6'b101001, 1'b0, 1'b0);
    step(3);
    chg_aux = '0;
    expect_in(2, "ld_strobe_ign", 9'h121, 6'b101001, 1'b0, 1'b0);
    step(4);

    // held aux strobe toggles once
    chg_aux[3] = 1'b1;
    expect_in(2, "aux_held_tog", 9'h121, 6'b100001, 1'b0, 1'b0);
    expect_in(30, "aux_held_once", 9'h121, 6'b100001, 1'b0, 1'b0);
    step(50);
    chg_aux[3] = 1'b0;
    expect_in(3, "aux_release", 9'h121, 6'b100001, 1'b0, 1'b0);
    step(5);
    chg_aux[1] = 1'b1;
    expect_in(2, "aux_tog1", 9'h121, 6'b100011, 1'b0, 1'b0);
    @(negedge CLK);
    chg_aux[1] = 1'b0;
    step(4);

    // red_check after 1000 ticks of NS+TH red
    t_rc = (ld / 10 + 1) * 10 + 9990;
    wait_until(t_rc - 3);
    expect_abs(t_rc, "rc_pre", 9'h121, 6'b100011, 1'b0, 1'b0);
    expect_abs(t_rc + 1, "rc_rise", 9'h121, 6'b100011, 1'b1, 1'b0);
    wait_until(t_rc + 4);

    expect_in(2, "ns_green", 9'h109, 6'b100011, 1'b1, 1'b0);
    expect_in(3, "rc_drop", 9'h109, 6'b100011, 1'b0, 1'b0);
    pulse_veh(1);
    step(4);

    // TH green, yellow, early request, duplicate, deferred red
    expect_in(2, "th_green", 9'h049, 6'b100011, 1'b0, 1'b0);
    pulse_veh(2);
    step(3);
    ye = cyc + 2;
    expect_in(2, "th_yellow", 9'h089, 6'b100011, 1'b0, 1'b0);
    pulse_veh(2);
    wait_until(ye + 10000);
    expect_in(2, "th_pend", 9'h089, 6'b100011, 1'b0, 1'b0);
    expect_in(3, "th_pend_nodup", 9'h089, 6'b100011, 1'b0, 1'b0);
    pulse_veh(2);
    wait_until(ye + 20000);
    expect_in(2, "th_dup", 9'h089, 6'b100011, 1'b0, 1'b1);
    expect_in(3, "th_dup_clr", 9'h089, 6'b100011, 1'b0, 1'b0);
    pulse_veh(2);
    r_th = (ye / 10 + 1) * 10 + 29990;
    wait_until(r_th - 3);
    expect_abs(r_th - 1, "th_yel_hold", 9'h089, 6'b100011, 1'b0, 1'b0);
    expect_abs(r_th, "th_red", 9'h109, 6'b100011, 1'b0, 1'b0);
    wait_until(r_th + 2);

    // NS into yellow with a pending request, then async reset
    expect_in(2, "ns_yellow", 9'h111, 6'b100011, 1'b0, 1'b0);
    pulse_veh(1);
    step(3);
    expect_in(2, "ns_pend", 9'h111, 6'b100011, 1'b0, 1'b0);
    pulse_veh(1);
    step(4);
    drain();
    @(posedge CLK);
    #2;
    reset_general_n = 1'b0;
    enable_general  = 1'b0;
    #1;
    expect_abs(0, "async_rst", 9'h124, 6'h00, 1'b0, 1'b0);
    @(negedge CLK);
    step(2);
    reset_general_n = 1'b1;
    step(3);
    expect_in(1, "post_rst_idle", 9'h124, 6'h00, 1'b0, 1'b0);
    step(2);
    set_veh = 3'b111; set_aux = 6'h00;
    enable_general = 1'b1;
    expect_in(2, "reload_red", 9'h124, 6'h00, 1'b0, 1'b0);
    step(4);
    expect_in(2, "ns_after_rst", 9'h10C, 6'h00, 1'b0, 1'b0);
    pulse_veh(1);
    step(4);

`ifdef FLASH_YELLOW_EN
    set_veh = 3'b110; set_aux = 6'b101001;
    enable_general = 1'b0;
    f1 = ((cyc + 2) / 10 + 1) * 10 + 4990;
    expect_in(1, "fl_first", 9'h10C, 6'h00, 1'b0, 1'b0);
    expect_in(2, "fl_start", 9'h092, 6'h00, 1'b0, 1'b0);
    wait_until(f1 - 2);
    expect_abs(f1 - 1, "fl_on_end", 9'h092, 6'h00, 1'b0, 1'b0);
    expect_abs(f1, "fl_off", 9'h000, 6'h00, 1'b0, 1'b0);
    wait_until(f1 + 4997);
    expect_abs(f1 + 4999, "fl_off_end", 9'h000, 6'h00, 1'b0, 1'b0);
    expect_abs(f1 + 5000, "fl_on2", 9'h092, 6'h00, 1'b0, 1'b0);
    wait_until(f1 + 5003);
    enable_general = 1'b1;
    expect_in(2, "fl_reload", 9'h121, 6'b101001, 1'b0, 1'b0);
    step(4);
`endif

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
